// File: rtl/frame_sequencer_if.sv
// Bundle between the frame sequencer and its surroundings: control requests,
// descriptor fetch, eval stack / LVA / call stack handshakes and frame state.
`timescale 1ns/1ps
interface frame_sequencer_if;
  logic        invoke;
  logic        ret;
  logic [15:0] method_ref;
  logic [15:0] pc_in;
  logic [15:0] desc_index;
  logic [31:0] desc_data;
  logic        ev_trigger;
  logic        ev_push;
  logic [31:0] ev_read;
  logic        ev_done;
  logic        lva_trigger;
  logic        lva_write;
  logic [15:0] lva_addr;
  logic [31:0] lva_wdata;
  logic        lva_done;
  logic        cs_trigger;
  logic        cs_push;
  logic [39:0] cs_wdata;
  logic [39:0] cs_rdata;
  logic        cs_done;
  logic        pc_load;
  logic [15:0] pc_next;
  logic [15:0] lva_base;
  logic [7:0]  lva_size;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  invoke, ret, method_ref, pc_in, desc_data, ev_read, ev_done,
           lva_done, cs_rdata, cs_done,
    output desc_index, ev_trigger, ev_push, lva_trigger, lva_write, lva_addr,
           lva_wdata, cs_trigger, cs_push, cs_wdata, pc_load, pc_next,
           lva_base, lva_size, busy, done, error
  );

  modport slave (
    output invoke, ret, method_ref, pc_in, desc_data, ev_read, ev_done,
           lva_done, cs_rdata, cs_done,
    input  desc_index, ev_trigger, ev_push, lva_trigger, lva_write, lva_addr,
           lva_wdata, cs_trigger, cs_push, cs_wdata, pc_load, pc_next,
           lva_base, lva_size, busy, done, error
  );
endinterface

// File: rtl/frame_sequencer.sv
// Invoke/return sequencer owning the current frame (base, size, depth).
// Triggers are one-cycle pulses; every wait state holds until its done input.
`timescale 1ns/1ps
module frame_sequencer #(
  parameter int LVA_SIZE = 2048,
  parameter int CS_DEPTH = 256,
  parameter int DESC_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  frame_sequencer_if.master bus
);

  localparam int DW = $clog2(CS_DEPTH + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DESC_WAIT = 4'd1;
  localparam logic [3:0] S_DESC_CAP  = 4'd2;
  localparam logic [3:0] S_CHECK     = 4'd3;
  localparam logic [3:0] S_POP       = 4'd4;
  localparam logic [3:0] S_POP_WAIT  = 4'd5;
  localparam logic [3:0] S_WR        = 4'd6;
  localparam logic [3:0] S_WR_WAIT   = 4'd7;
  localparam logic [3:0] S_CS_PUSH   = 4'd8;
  localparam logic [3:0] S_CS_WAIT   = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_RET_POP   = 4'd11;
  localparam logic [3:0] S_RET_WAIT  = 4'd12;

  localparam logic [DW-1:0] DEPTH_MAX  = DW'(CS_DEPTH);
  localparam logic [16:0]   LVA_LIMIT  = 17'(LVA_SIZE);
  localparam logic [7:0]    DESC_WAITS = 8'(DESC_LAT - 1);

  logic [3:0]    state_q, state_d;
  logic [7:0]    cnt_q;
  logic [15:0]   desc_index_q;
  logic [15:0]   pc_q;
  logic [15:0]   code_q;
  logic [7:0]    argc_q;
  logic [7:0]    lvamax_q;
  logic [15:0]   new_base_q;
  logic [7:0]    k_q;
  logic [15:0]   lva_addr_q;
  logic [31:0]   lva_wdata_q;
  logic [39:0]   cs_wdata_q;
  logic [15:0]   pc_next_q;
  logic [15:0]   lva_base_q;
  logic [7:0]    lva_size_q;
  logic [DW-1:0] depth_q;
  logic          ret_err_q;

  logic          chk_fail;
  logic          ret_accept;
  logic          ret_reject;

  // Frame end is compared in 17 bits so a base near the top cannot wrap past the limit.
  assign chk_fail = (depth_q == DEPTH_MAX) ||
                    (argc_q > lvamax_q) ||
                    (({1'b0, new_base_q} + {9'd0, lvamax_q}) > LVA_LIMIT);

  assign ret_accept = !bus.invoke && bus.ret && (depth_q != '0);
  assign ret_reject = !bus.invoke && bus.ret && (depth_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.invoke)      state_d = S_DESC_WAIT;
        else if (ret_accept) state_d = S_RET_POP;
      end
      S_DESC_WAIT: if (cnt_q == 8'd0) state_d = S_DESC_CAP;
      S_DESC_CAP:  state_d = S_CHECK;
      S_CHECK: begin
        if (chk_fail)            state_d = S_IDLE;
        else if (argc_q == 8'd0) state_d = S_CS_PUSH;
        else                     state_d = S_POP;
      end
      S_POP:      state_d = S_POP_WAIT;
      S_POP_WAIT: if (bus.ev_done) state_d = S_WR;
      S_WR:       state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.lva_done) state_d = (k_q == 8'd1) ? S_CS_PUSH : S_POP;
      end
      S_CS_PUSH:  state_d = S_CS_WAIT;
      S_CS_WAIT:  if (bus.cs_done) state_d = S_JUMP;
      S_JUMP:     state_d = S_IDLE;
      S_RET_POP:  state_d = S_RET_WAIT;
      S_RET_WAIT: if (bus.cs_done) state_d = S_JUMP;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      desc_index_q <= '0;
      pc_q         <= '0;
      code_q       <= '0;
      argc_q       <= '0;
      lvamax_q     <= '0;
      new_base_q   <= '0;
      k_q          <= '0;
      lva_addr_q   <= '0;
      lva_wdata_q  <= '0;
      cs_wdata_q   <= '0;
      pc_next_q    <= '0;
      lva_base_q   <= '0;
      lva_size_q   <= '0;
      depth_q      <= '0;
      ret_err_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_err_q <= (state_q == S_IDLE) && ret_reject;
      case (state_q)
        S_IDLE: begin
          if (bus.invoke) begin
            desc_index_q <= bus.method_ref;
            pc_q         <= bus.pc_in;
            cnt_q        <= DESC_WAITS;
          end
        end
        S_DESC_WAIT: if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        S_DESC_CAP: begin
          code_q     <= bus.desc_data[31:16];
          argc_q     <= bus.desc_data[15:8];
          lvamax_q   <= bus.desc_data[7:0];
          new_base_q <= lva_base_q + {8'd0, lva_size_q};
        end
        S_CHECK: begin
          if (!chk_fail) begin
            k_q        <= argc_q;
            cs_wdata_q <= {pc_q + 16'd3, lva_size_q, lva_base_q};
          end
        end
        // Arguments are filled from the highest slot down: the top of stack is the last one.
        S_POP_WAIT: begin
          if (bus.ev_done) begin
            lva_addr_q  <= new_base_q + {8'd0, k_q} - 16'd1;
            lva_wdata_q <= bus.ev_read;
          end
        end
        S_WR_WAIT: if (bus.lva_done) k_q <= k_q - 8'd1;
        S_CS_WAIT: begin
          if (bus.cs_done) begin
            lva_base_q <= new_base_q;
            lva_size_q <= lvamax_q;
            depth_q    <= depth_q + 1'b1;
            pc_next_q  <= code_q;
          end
        end
        S_RET_WAIT: begin
          if (bus.cs_done) begin
            pc_next_q  <= bus.cs_rdata[39:24];
            lva_size_q <= bus.cs_rdata[23:16];
            lva_base_q <= bus.cs_rdata[15:0];
            depth_q    <= depth_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.desc_index  = desc_index_q;
  assign bus.ev_trigger  = (state_q == S_POP);
  assign bus.ev_push     = 1'b0;
  assign bus.lva_trigger = (state_q == S_WR);
  assign bus.lva_write   = (state_q == S_WR);
  assign bus.lva_addr    = lva_addr_q;
  assign bus.lva_wdata   = lva_wdata_q;
  assign bus.cs_trigger  = (state_q == S_CS_PUSH) || (state_q == S_RET_POP);
  assign bus.cs_push     = (state_q == S_CS_PUSH) || (state_q == S_CS_WAIT);
  assign bus.cs_wdata    = cs_wdata_q;
  assign bus.pc_load     = (state_q == S_JUMP);
  assign bus.done        = (state_q == S_JUMP);
  assign bus.pc_next     = pc_next_q;
  assign bus.lva_base    = lva_base_q;
  assign bus.lva_size    = lva_size_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.error       = ((state_q == S_CHECK) && chk_fail) || ret_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized scoreboard bench for frame_sequencer with delayed-done responders.
`timescale 1ns/1ps
module tb_frame_sequencer;
  localparam int LVA_SZ = 64;
  localparam int CSD    = 4;
  localparam int DLAT   = 2;

  typedef struct packed { logic [15:0] addr; logic [31:0] data; } lva_exp_t;
  typedef struct packed { logic push; logic [39:0] data; } cs_exp_t;
  typedef struct packed { logic err; logic [15:0] pc; logic [15:0] base; logic [7:0] size; } end_exp_t;
  typedef struct { logic [15:0] pc; logic [7:0] size; logic [15:0] base; } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_sequencer_if bus_if();
  frame_sequencer #(.LVA_SIZE(LVA_SZ), .CS_DEPTH(CSD), .DESC_LAT(DLAT)) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  int n_vec = 0;
  int n_mis = 0;

  lva_exp_t exp_lva[$];
  cs_exp_t  exp_cs[$];
  end_exp_t exp_end[$];
  int       exp_ev = 0;

  logic [15:0] m_base = '0;
  logic [7:0]  m_size = '0;
  logic [15:0] m_pc   = '0;
  int          m_depth = 0;
  frame_t      m_stack[$];

  logic [31:0] ev_stack[$];
  logic [39:0] cs_mem[$];
  int ev_dly = 1, lva_dly = 1, cs_dly = 1;
  int gen = 0;
  logic ev_out = 0, lva_out = 0, cs_out = 0;
  int lva_trig_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Descriptor memory with a DESC_LAT-cycle read pipeline.
  logic [31:0] rom [16];
  logic [31:0] d1, d2;
  initial for (int i = 0; i < 16; i++) rom[i] = '0;
  always @(posedge clk) begin
    d1 <= rom[bus_if.desc_index[3:0]];
    d2 <= d1;
  end
  assign bus_if.desc_data = d2;

  initial begin : ev_resp
    int g;
    bus_if.ev_done = 1'b0;
    bus_if.ev_read = '0;
    forever begin
      @(negedge clk);
      bus_if.ev_done = 1'b0;
      if (bus_if.ev_trigger) begin
        g = gen;
        repeat (ev_dly) @(negedge clk);
        if (g == gen) begin
          bus_if.ev_read = (ev_stack.size() > 0) ? ev_stack.pop_back() : 32'hDEAD_BEEF;
          bus_if.ev_done = 1'b1;
        end
      end
    end
  end

  initial begin : lva_resp
    int g;
    bus_if.lva_done = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.lva_done = 1'b0;
      if (bus_if.lva_trigger) begin
        g = gen;
        repeat (lva_dly) @(negedge clk);
        if (g == gen) bus_if.lva_done = 1'b1;
      end
    end
  end

  initial begin : cs_resp
    int g;
    logic push;
    logic [39:0] wd;
    bus_if.cs_done  = 1'b0;
    bus_if.cs_rdata = '0;
    forever begin
      @(negedge clk);
      bus_if.cs_done = 1'b0;
      if (bus_if.cs_trigger) begin
        g = gen;
        push = bus_if.cs_push;
        wd = bus_if.cs_wdata;
        repeat (cs_dly) @(negedge clk);
        if (g == gen) begin
          if (push) cs_mem.push_back(wd);
          else bus_if.cs_rdata = (cs_mem.size() > 0) ? cs_mem.pop_back() : 40'h0;
          bus_if.cs_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops and compares whatever the DUT presents.
  initial begin : monitor
    lva_exp_t le;
    cs_exp_t  ce;
    end_exp_t ee;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (bus_if.ev_done)  ev_out  = 1'b0;
        if (bus_if.lva_done) lva_out = 1'b0;
        if (bus_if.cs_done)  cs_out  = 1'b0;
        if (bus_if.ev_trigger) begin
          chk("ev_one_trigger_per_done", ev_out, 0);
          ev_out = 1'b1;
          chk("ev_push_low", bus_if.ev_push, 0);
          chk("ev_pop_expected", exp_ev > 0, 1);
          if (exp_ev > 0) exp_ev--;
        end
        if (bus_if.lva_trigger) begin
          lva_trig_cnt++;
          chk("lva_one_trigger_per_done", lva_out, 0);
          lva_out = 1'b1;
          chk("lva_write", bus_if.lva_write, 1);
          chk("lva_write_expected", exp_lva.size() != 0, 1);
          if (exp_lva.size() != 0) begin
            le = exp_lva.pop_front();
            chk("lva_addr", bus_if.lva_addr, le.addr);
            chk("lva_wdata", bus_if.lva_wdata, le.data);
          end
        end
        if (bus_if.cs_trigger) begin
          chk("cs_one_trigger_per_done", cs_out, 0);
          cs_out = 1'b1;
          chk("cs_op_expected", exp_cs.size() != 0, 1);
          if (exp_cs.size() != 0) begin
            ce = exp_cs.pop_front();
            chk("cs_push", bus_if.cs_push, ce.push);
            if (ce.push) chk("cs_wdata", bus_if.cs_wdata, ce.data);
          end
        end
        if (bus_if.done || bus_if.error) begin
          chk("completion_expected", exp_end.size() != 0, 1);
          if (exp_end.size() != 0) begin
            ee = exp_end.pop_front();
            chk("error", bus_if.error, ee.err);
            chk("done", bus_if.done, !ee.err);
            chk("pc_load", bus_if.pc_load, !ee.err);
            chk("pc_next", bus_if.pc_next, ee.pc);
            chk("lva_base", bus_if.lva_base, ee.base);
            chk("lva_size", bus_if.lva_size, ee.size);
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_pc_next", bus_if.pc_next, 0);
    chk("rst_lva_base", bus_if.lva_base, 0);
    chk("rst_lva_size", bus_if.lva_size, 0);
    chk("rst_desc_index", bus_if.desc_index, 0);
    chk("rst_triggers", {bus_if.ev_trigger, bus_if.lva_trigger, bus_if.cs_trigger, bus_if.lva_write, bus_if.cs_push}, 0);
    chk("rst_pulses", {bus_if.pc_load, bus_if.done, bus_if.error}, 0);
    chk("rst_lva_addr", bus_if.lva_addr, 0);
    chk("rst_lva_wdata", bus_if.lva_wdata, 0);
    chk("rst_cs_wdata", bus_if.cs_wdata, 0);
  endtask

  task automatic wait_idle(input bit noise);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      bus_if.invoke = 1'b0;
      bus_if.ret = 1'b0;
      if (exp_end.size() == 0) break;
      if (noise && bus_if.busy && $urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          bus_if.invoke = 1'b1;
          bus_if.method_ref = 16'($urandom);
          bus_if.pc_in = 16'($urandom);
        end else begin
          bus_if.ret = 1'b1;
        end
      end
    end
    chk("op_completes", exp_end.size(), 0);
    @(posedge clk);
    #2;
    chk("busy_falls", bus_if.busy, 0);
    chk("lva_writes_drained", exp_lva.size(), 0);
    chk("cs_ops_drained", exp_cs.size(), 0);
    chk("ev_pops_drained", exp_ev, 0);
  endtask

  task automatic do_invoke(input logic [15:0] code, input logic [7:0] argc,
                           input logic [7:0] lvamax, input bit wait_done, input bit noise);
    logic [15:0] nb, pc, mref;
    int idx;
    frame_t f;
    idx = $urandom_range(0, 15);
    rom[idx] = {code, argc, lvamax};
    mref = 16'($urandom);
    mref[3:0] = 4'(idx);
    pc = 16'($urandom);
    nb = m_base + {8'd0, m_size};
    if (m_depth == CSD || argc > lvamax || (int'(nb) + int'(lvamax)) > LVA_SZ) begin
      exp_end.push_back('{err: 1'b1, pc: m_pc, base: m_base, size: m_size});
    end else begin
      for (int j = 0; j < int'(argc); j++)
        exp_lva.push_back('{addr: nb + 16'(int'(argc) - 1 - j),
                            data: ev_stack[ev_stack.size() - 1 - j]});
      exp_ev += int'(argc);
      exp_cs.push_back('{push: 1'b1, data: {pc + 16'd3, m_size, m_base}});
      f.pc = pc + 16'd3; f.size = m_size; f.base = m_base;
      m_stack.push_back(f);
      m_base = nb;
      m_size = lvamax;
      m_depth++;
      m_pc = code;
      exp_end.push_back('{err: 1'b0, pc: code, base: nb, size: lvamax});
    end
    @(posedge clk);
    #2;
    bus_if.invoke = 1'b1;
    bus_if.ret = ($urandom_range(0, 1) == 1);
    bus_if.method_ref = mref;
    bus_if.pc_in = pc;
    if (wait_done) wait_idle(noise);
  endtask

  task automatic do_ret(input bit noise);
    frame_t f;
    if (m_depth == 0) begin
      exp_end.push_back('{err: 1'b1, pc: m_pc, base: m_base, size: m_size});
    end else begin
      f = m_stack.pop_back();
      exp_cs.push_back('{push: 1'b0, data: 40'h0});
      m_depth--;
      m_pc = f.pc;
      m_base = f.base;
      m_size = f.size;
      exp_end.push_back('{err: 1'b0, pc: f.pc, base: f.base, size: f.size});
    end
    @(posedge clk);
    #2;
    bus_if.ret = 1'b1;
    wait_idle(noise);
  endtask

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] lm, ac;
    int start;
    bus_if.invoke = 1'b0;
    bus_if.ret = 1'b0;
    bus_if.method_ref = '0;
    bus_if.pc_in = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs();
    rst = 1'b0;

    // Two arguments (11 then 22 on top) into a 3-word frame at base 0.
    ev_stack.push_back(32'd11);
    ev_stack.push_back(32'd22);
    do_invoke(16'h0040, 8'd2, 8'd3, 1, 0);
    do_invoke(16'h0080, 8'd0, 8'd4, 1, 0);
    do_invoke(16'h00C0, 8'd0, 8'd4, 1, 0);
    do_ret(0);
    do_ret(0);
    do_ret(0);
    do_ret(0);

    // Frame too large for the LVA, then too many arguments.
    do_invoke(16'h0100, 8'd0, 8'd70, 1, 0);
    for (int i = 0; i < 5; i++) ev_stack.push_back($urandom);
    do_invoke(16'h0140, 8'd5, 8'd2, 1, 0);

    // Call stack full.
    for (int i = 0; i < CSD + 1; i++) do_invoke(16'h0200 + 16'(i), 8'd0, 8'd1, 1, 0);
    for (int i = 0; i < CSD; i++) do_ret(0);

    // Randomized traffic with slow responders and requests issued while busy.
    for (int op = 0; op < 70; op++) begin
      ev_dly = $urandom_range(1, 5);
      lva_dly = $urandom_range(1, 5);
      cs_dly = $urandom_range(1, 5);
      if ($urandom_range(0, 9) < 6) begin
        lm = 8'($urandom_range(0, 12));
        if ($urandom_range(0, 7) == 0) ac = lm + 8'($urandom_range(1, 3));
        else ac = 8'($urandom_range(0, int'(lm)));
        for (int k = 0; k < int'(ac); k++) ev_stack.push_back($urandom);
        do_invoke(16'($urandom), ac, lm, 1, 1);
      end else begin
        do_ret(1);
      end
    end
    while (m_depth > 0) do_ret(1);

    // Reset while the second of three argument writes is outstanding.
    ev_dly = 1;
    lva_dly = 5;
    cs_dly = 1;
    for (int k = 0; k < 3; k++) ev_stack.push_back($urandom);
    start = lva_trig_cnt;
    do_invoke(16'h0300, 8'd3, 8'd3, 0, 0);
    for (int i = 0; i < 200 && lva_trig_cnt < start + 2; i++) begin
      @(posedge clk);
      #2;
      bus_if.invoke = 1'b0;
      bus_if.ret = 1'b0;
    end
    chk("reset_test_second_write_seen", lva_trig_cnt - start, 2);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    gen++;
    @(posedge clk);
    #2;
    chk_reset_outputs();
    exp_lva.delete();
    exp_cs.delete();
    exp_end.delete();
    exp_ev = 0;
    cs_mem.delete();
    m_stack.delete();
    m_base = '0;
    m_size = '0;
    m_pc = '0;
    m_depth = 0;
    ev_out = 1'b0;
    lva_out = 1'b0;
    cs_out = 1'b0;
    rst = 1'b0;
    lva_dly = 1;

    ev_stack.push_back(32'hCAFE_0001);
    do_invoke(16'h0400, 8'd1, 8'd2, 1, 0);
    do_ret(0);
    do_ret(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
